// File: rtl/fifo_rd_packer.sv
// Read-side packer: gathers PACK consecutive FIFO words into one wide output word,
// with flush for partial words and a sticky error for unsolicited read data.
module fifo_rd_packer #(
   parameter int WIDTH = 8,
   parameter int PACK  = 4
) (
   input  logic                  rclk,
   input  logic                  rst,
   input  logic                  empty,
   input  logic                  valid,
   input  logic [WIDTH-1:0]      rdata,
   output logic                  ren,
   input  logic                  flush,
   output logic [WIDTH*PACK-1:0] out_data,
   output logic [PACK-1:0]       out_keep,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  err
);

   localparam int CW = $clog2(PACK + 1);
   localparam int SW = CW + 1;
   localparam logic [CW-1:0] PACK_C = CW'(PACK);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_STALL = 2'd2,
      S_FLUSH = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [CW-1:0]         infl_q, infl_d;
   logic [WIDTH*PACK-1:0] acc_q, acc_d;
   logic [WIDTH*PACK-1:0] odata_q, odata_d;
   logic [PACK-1:0]       okeep_q, okeep_d;
   logic                  ovalid_q, ovalid_d;
   logic                  err_q, err_d;

   logic                  take_s;
   logic [CW-1:0]         cnt_w_s;
   logic [CW-1:0]         infl_w_s;
   logic [WIDTH*PACK-1:0] acc_w_s;
   logic                  full_s;
   logic                  out_free_s;
   logic                  move_full_s;
   logic [SW-1:0]         occ_s;
   logic [PACK-1:0]       part_keep_s;
   logic                  ren_s;

   // Datapath: accept read data into the accumulator and derive the read enable.
   // A word completing this cycle and moving out frees its lanes immediately, so
   // reads keep streaming without a bubble.
   always_comb begin
      take_s  = valid && (infl_q != {CW{1'b0}});
      acc_w_s = acc_q;
      for (int i = 0; i < PACK; i++) begin
         if (take_s && (cnt_q == CW'(i))) begin
            acc_w_s[i*WIDTH +: WIDTH] = rdata;
         end else begin
            acc_w_s[i*WIDTH +: WIDTH] = acc_q[i*WIDTH +: WIDTH];
         end
      end
      cnt_w_s     = cnt_q + CW'(take_s);
      full_s      = (cnt_w_s == PACK_C);
      out_free_s  = !ovalid_q || out_ready;
      move_full_s = full_s && out_free_s;
      if (move_full_s) begin
         occ_s = SW'(cnt_q) + SW'(infl_q) - SW'(PACK);
      end else begin
         occ_s = SW'(cnt_q) + SW'(infl_q);
      end
      ren_s = !rst && !empty && (occ_s < SW'(PACK)) &&
              ((state_q == S_IDLE) || (state_q == S_FILL));
      infl_w_s = infl_q + CW'(ren_s) - CW'(take_s);
      for (int i = 0; i < PACK; i++) begin
         part_keep_s[i] = (CW'(i) < cnt_w_s);
      end
   end

   // Next-state and output-register control.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_w_s;
      infl_d   = infl_w_s;
      acc_d    = acc_w_s;
      odata_d  = odata_q;
      okeep_d  = okeep_q;
      ovalid_d = ovalid_q && !out_ready;
      err_d    = err_q || (valid && (infl_q == {CW{1'b0}}));
      case (state_q)
         S_IDLE, S_FILL: begin
            if (full_s) begin
               if (out_free_s) begin
                  odata_d  = acc_w_s;
                  okeep_d  = {PACK{1'b1}};
                  ovalid_d = 1'b1;
                  cnt_d    = {CW{1'b0}};
                  acc_d    = {(WIDTH*PACK){1'b0}};
                  // A flush coinciding with the move targets whatever is still in flight.
                  if (infl_w_s != {CW{1'b0}}) begin
                     state_d = flush ? S_FLUSH : S_FILL;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  state_d = flush ? S_FLUSH : S_STALL;
               end
            end else if ((cnt_w_s != {CW{1'b0}}) || (infl_w_s != {CW{1'b0}})) begin
               state_d = flush ? S_FLUSH : S_FILL;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_STALL: begin
            if (out_free_s) begin
               odata_d  = acc_w_s;
               okeep_d  = {PACK{1'b1}};
               ovalid_d = 1'b1;
               cnt_d    = {CW{1'b0}};
               acc_d    = {(WIDTH*PACK){1'b0}};
               state_d  = S_IDLE;
            end else begin
               state_d = flush ? S_FLUSH : S_STALL;
            end
         end
         S_FLUSH: begin
            if ((infl_w_s == {CW{1'b0}}) && out_free_s) begin
               if (cnt_w_s != {CW{1'b0}}) begin
                  odata_d  = acc_w_s;
                  okeep_d  = part_keep_s;
                  ovalid_d = 1'b1;
               end else begin
                  ovalid_d = ovalid_q && !out_ready;
               end
               cnt_d   = {CW{1'b0}};
               acc_d   = {(WIDTH*PACK){1'b0}};
               state_d = S_IDLE;
            end else begin
               state_d = S_FLUSH;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge rclk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= {CW{1'b0}};
         infl_q   <= {CW{1'b0}};
         acc_q    <= {(WIDTH*PACK){1'b0}};
         odata_q  <= {(WIDTH*PACK){1'b0}};
         okeep_q  <= {PACK{1'b0}};
         ovalid_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         infl_q   <= infl_d;
         acc_q    <= acc_d;
         odata_q  <= odata_d;
         okeep_q  <= okeep_d;
         ovalid_q <= ovalid_d;
         err_q    <= err_d;
      end
   end

   assign ren       = ren_s;
   assign out_data  = odata_q;
   assign out_keep  = okeep_q;
   assign out_valid = ovalid_q;
   assign err       = err_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer with a small behavioural FIFO answering ren.
module tb_fifo_rd_packer;

   logic        rclk = 1'b0;
   logic        rst;
   logic        empty;
   logic        valid;
   logic [7:0]  rdata;
   logic        ren;
   logic        flush;
   logic [31:0] out_data;
   logic [3:0]  out_keep;
   logic        out_valid;
   logic        out_ready;
   logic        err;

   fifo_rd_packer #(.WIDTH(8), .PACK(4)) dut (
      .rclk      (rclk),
      .rst       (rst),
      .empty     (empty),
      .valid     (valid),
      .rdata     (rdata),
      .ren       (ren),
      .flush     (flush),
      .out_data  (out_data),
      .out_keep  (out_keep),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .err       (err)
   );

   always #5 rclk = ~rclk;

   logic [7:0] mem [0:63];
   int         wp = 0;
   int         rp = 0;
   logic       m_vld = 1'b0;
   logic [7:0] m_data = 8'h00;
   logic       force_vld;
   logic [7:0] force_data;

   assign empty = (wp == rp);
   assign valid = m_vld | force_vld;
   assign rdata = force_vld ? force_data : m_data;

   // FIFO read port: data appears the cycle after an accepted ren.
   always @(posedge rclk) begin
      if (ren) begin
         m_vld  <= 1'b1;
         m_data <= mem[rp[5:0]];
         rp     <= rp + 1;
      end else begin
         m_vld  <= 1'b0;
      end
   end

   int          n_cmp = 0;
   int          n_err = 0;
   int          ren_cnt, ov_cnt, first_ov, idx, hold_cnt;
   logic [31:0] wq [$];
   logic [3:0]  kq [$];

   task automatic push(input logic [7:0] d);
      mem[wp[5:0]] = d;
      wp = wp + 1;
   endtask

   task automatic tick();
      @(posedge rclk);
      #1;
   endtask

   task automatic clear();
      ren_cnt = 0; ov_cnt = 0; first_ov = -1; idx = 0; hold_cnt = 0;
      wq.delete();
      kq.delete();
   endtask

   task automatic smp();
      #1;
      if (ren) ren_cnt++;
      if (out_valid) begin
         ov_cnt++;
         if (first_ov < 0) first_ov = idx;
      end
      if (out_valid && out_ready) begin
         wq.push_back(out_data);
         kq.push_back(out_keep);
      end
      if (out_valid && (out_data == 32'h04030201)) hold_cnt++;
      idx++;
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         tick();
         smp();
      end
   endtask

   function automatic logic [31:0] getw(input int i);
      if (i < wq.size()) return wq[i];
      return 32'hxxxxxxxx;
   endfunction

   function automatic logic [31:0] getk(input int i);
      if (i < kq.size()) return {28'h0, kq[i]};
      return 32'hxxxxxxxx;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
      force_vld = 1'b0; force_data = 8'h00;
      clear();

      // Single full word, streaming
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      repeat (3) tick();
      #1;
      chk("rst_ren", {31'h0, ren}, 32'd0);
      chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
      chk("rst_out_keep", {28'h0, out_keep}, 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_err", {31'h0, err}, 32'd0);
      tick(); rst = 1'b0; clear(); smp();
      chk("t1_first_ren", {31'h0, ren}, 32'd1);
      cycles(7);
      chk("t1_ren_cnt", ren_cnt, 32'd4);
      chk("t1_ov_cycles", ov_cnt, 32'd1);
      chk("t1_ov_latency", first_ov, 32'd5);
      chk("t1_words", wq.size(), 32'd1);
      chk("t1_data", getw(0), 32'h44332211);
      chk("t1_keep", getk(0), 32'hF);

      // Backpressure: first word held, second stalls
      tick();
      out_ready = 1'b0;
      for (int i = 1; i <= 12; i++) push(8'(i));
      clear(); smp();
      cycles(11);
      chk("t2_hold_valid", {31'h0, out_valid}, 32'd1);
      chk("t2_hold_data", out_data, 32'h04030201);
      chk("t2_stall_ren", ren_cnt, 32'd8);
      tick(); out_ready = 1'b1; smp();
      cycles(10);
      chk("t2_hold_cycles", hold_cnt, 32'd8);
      chk("t2_words", wq.size(), 32'd3);
      chk("t2_w0", getw(0), 32'h04030201);
      chk("t2_w1", getw(1), 32'h08070605);
      chk("t2_w2", getw(2), 32'h0C0B0A09);
      chk("t2_ren_cnt", ren_cnt, 32'd12);

      // Partial word flushed after FIFO runs dry
      tick();
      push(8'hA1); push(8'hB2); push(8'hC3);
      clear(); smp();
      cycles(4);
      tick(); flush = 1'b1; smp();
      tick(); flush = 1'b0; smp();
      cycles(4);
      chk("t3_words", wq.size(), 32'd1);
      chk("t3_data", getw(0), 32'h00C3B2A1);
      chk("t3_keep", getk(0), 32'h7);
      chk("t3_ov_idx", first_ov, 32'd7);
      chk("t3_ren_cnt", ren_cnt, 32'd3);

      // Flush with reads in flight
      tick();
      push(8'h5A); push(8'h6B); push(8'h7C);
      clear(); smp();
      tick(); flush = 1'b1; smp();
      tick(); flush = 1'b0; smp();
      chk("t4_no_ren_after_flush", {31'h0, ren}, 32'd0);
      chk("t4_ren_cnt", ren_cnt, 32'd2);
      tick(); smp();
      chk("t4_valid", {31'h0, out_valid}, 32'd1);
      chk("t4_data", out_data, 32'h00006B5A);
      chk("t4_keep", {28'h0, out_keep}, 32'h3);
      cycles(3);
      tick(); flush = 1'b1; smp();
      tick(); flush = 1'b0; smp();
      cycles(3);
      chk("t4_words", wq.size(), 32'd2);
      chk("t4_tail_data", getw(1), 32'h0000007C);
      chk("t4_tail_keep", getk(1), 32'h1);
      chk("t4_err", {31'h0, err}, 32'd0);

      // Flush with nothing accumulated is ignored
      clear();
      tick(); flush = 1'b1; smp();
      tick(); flush = 1'b0; smp();
      cycles(3);
      chk("t5_ignored_flush", ov_cnt, 32'd0);
      chk("t5_empty_no_ren", ren_cnt, 32'd0);

      // Unsolicited valid sets sticky err
      tick(); force_vld = 1'b1; force_data = 8'hEE; smp();
      tick(); force_vld = 1'b0; smp();
      chk("t6_err_set", {31'h0, err}, 32'd1);
      cycles(4);
      chk("t6_err_sticky", {31'h0, err}, 32'd1);
      chk("t6_no_output", ov_cnt, 32'd0);

      // Reset with a held word and a partial accumulator
      tick();
      out_ready = 1'b0;
      push(8'h10); push(8'h11); push(8'h12); push(8'h13); push(8'h14); push(8'h15);
      clear(); smp();
      cycles(7);
      chk("t7_pre_valid", {31'h0, out_valid}, 32'd1);
      chk("t7_pre_data", out_data, 32'h13121110);
      tick(); rst = 1'b1; smp();
      chk("t7_rst_ren", {31'h0, ren}, 32'd0);
      tick(); rst = 1'b0; out_ready = 1'b1;
      push(8'h21); push(8'h22); push(8'h23); push(8'h24);
      clear(); smp();
      chk("t7_post_valid", {31'h0, out_valid}, 32'd0);
      chk("t7_post_keep", {28'h0, out_keep}, 32'd0);
      chk("t7_post_err", {31'h0, err}, 32'd0);
      cycles(8);
      chk("t7_words", wq.size(), 32'd1);
      chk("t7_data", getw(0), 32'h24232221);
      chk("t7_keep", getk(0), 32'hF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
